led_blink_scheduler: RTL and testbench
======================================

# led_blink_scheduler

Shares one status LED between `NUM_REQ` requesters. Each requester asks for an N-blink code. The scheduler grants requesters round-robin and plays exactly N on/off blinks at `FREQ_OUT`, derived from the `CLK_IN` clock rate. It then holds a dark inter-code gap and acknowledges completion. It sits between system status sources (error/heartbeat/mode logic) and the board LED pin, and generates LED timing internally in place of a free-running blinker.

## Interface
- `CLK_IN`, 300: input clock frequency in Hz.
- `FREQ_OUT`, 5: blink frequency in Hz. One blink is one on phase plus one off phase.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 4: width of each requested blink count.
- `GAP_PERIODS`, 2: dark gap after a code, in blink periods.

- `i_clk`  in  1  system clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  scheduler enable. Low aborts any sequence in progress.
- `i_req`  in  `NUM_REQ`  level request per requester. Hold until acked.
- `i_count`  in  `NUM_REQ*CNT_W`  blink count for requester k at bits [k*CNT_W +: CNT_W].
- `o_grant`  out  `NUM_REQ`  one-hot. Marks the requester being served, held for the whole sequence.
- `o_ack`  out  `NUM_REQ`  one-cycle completion pulse to the served requester.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_led`  out  1  LED drive, active-high.

## Operation
- Derived constants:
  - HALF = CLK_IN/(2*FREQ_OUT), integer division. Elaboration error if HALF < 1.
  - GAP_LEN = GAP_PERIODS*2*HALF.
  - Timer width = $clog2(GAP_LEN+1).
- FSM states: IDLE, ON, OFF, GAP.
- IDLE:
  - Arbitration happens when `i_en`=1, any `i_req` bit is set, and `o_ack` is 0 this cycle.
  - Winner is the first set `i_req` bit searching upward from `ptr`, wrapping around.
  - On a win: latch the winner into `o_grant` and its `i_count` into `remaining`.
  - If count ≠ 0: go to ON and load timer = HALF-1.
  - If count = 0: stay in IDLE, pulse `o_ack` for the winner next cycle, clear `o_grant`, and set `ptr` = winner+1 mod NUM_REQ. No blinks are played.
- ON: `o_led`=1. When timer = 0, go to OFF and reload HALF-1. Otherwise decrement the timer.
- OFF: `o_led`=0. When timer = 0, decrement `remaining`:
  - If the result is 0, go to GAP and load GAP_LEN-1.
  - Otherwise go to ON and load HALF-1.
- GAP: `o_led`=0. When timer = 0, go to IDLE with `o_ack`[winner]=1 for that first IDLE cycle, clear `o_grant`, and set `ptr` = winner+1 mod NUM_REQ.
- `i_count` and `i_req` changes after the grant are ignored until the sequence ends.
- `i_en` low in ON/OFF/GAP (abort):
  - Next cycle: IDLE, `o_led`=0, `o_grant`=0.
  - No `o_ack` is issued and `ptr` is unchanged, so the aborted requester is served first again.
  - Abort wins over a simultaneous phase end.
- Requesters drop `i_req` on the edge after seeing `o_ack`. Arbitration is blocked during the ack cycle, so a requester that drops its request is not re-served. A requester that keeps `i_req` high is served again in round-robin order.
- Maximum `i_count` is 2^CNT_W-1. No wrap; `remaining` never underflows.

## Timing
- All outputs are registered.
- Reset values: `o_led`=0, `o_grant`=0, `o_ack`=0, `o_busy`=0, state = IDLE, `ptr`=0, timer = 0, `remaining` = 0. Reset applies immediately, including mid-sequence.
- Request latency: `i_req` sampled high in IDLE → `o_grant` and `o_led` high on the next edge.
- Each ON and each OFF phase lasts exactly HALF cycles. The GAP lasts exactly GAP_LEN cycles.
- Grant-to-ack latency for count N: N*2*HALF + GAP_LEN cycles. The `o_ack` pulse is in the following cycle.
- Zero-count request: `o_ack` one cycle after the grant decision, with `o_led` never high.

## Structure
- Shared package `led_pkg`:
  - Enum `led_sched_state_t` with IDLE/ON/OFF/GAP.
  - Function `led_half_period(clk_in, freq_out)`, reused by other LED blocks.
- Sub-module `led_rr_arbiter`:
  - Purely combinational, parameterised by NUM_REQ.
  - Inputs `req` and `ptr`; outputs a one-hot `gnt` and a `valid` flag.
- FSM, timer and `remaining` counter live in the top module.

## Test plan
- Reset asserted, then released with `i_en`=1 and req0 (count=3) → `o_led` pulses 3×(30 high, 30 low) using defaults, stays dark 120 cycles, and `o_ack`[0] fires 300 cycles after the grant.
- req0 and req2 both held, counts 1 and 2 → grant order 0, 2, 0, 2. Each `o_ack` aligns to the correct requester.
- req1 with count=0 → `o_ack`[1] one cycle after the grant, `o_led` stays 0, `ptr` advances to 2.
- `i_en` dropped mid-ON of the second blink for req3 → IDLE next cycle, LED off, no ack. With `i_en` restored, req3 is re-granted and plays the full count.
- `i_reset_n` pulsed low during GAP → all outputs 0 asynchronously. After release, the pending req1 is granted before req2 because `ptr`=0.
- `i_count` changed from 2 to 5 mid-sequence → exactly 2 blinks are played.

Source files
------------

// File: rtl/led_pkg.sv
// Shared LED-block definitions: the scheduler state encoding and the
// half-period helper, which the other LED blocks also use.
package led_pkg;

    // Scheduler phases: waiting for a request, LED lit, LED dark between
    // blinks, and the dark gap that separates one code from the next.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } led_sched_state_t;

    // Returns the number of clk_in cycles in one half of a freq_out period.
    // The division truncates. A zero or negative frequency yields 0, which
    // the caller rejects during elaboration.
    function automatic int led_half_period(input int clk_in, input int freq_out);
        if (freq_out <= 0) begin
            return 0;
        end
        return clk_in / (2 * freq_out);
    endfunction

endpackage

// File: rtl/led_rr_arbiter.sv
// Combinational round-robin arbiter. It picks the first set request at or
// above ptr and wraps around to bit 0 when nothing is set above ptr.
module led_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               valid
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] sel;

    // Thermometer mask that keeps only positions at or above the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign mask[gi] = (PTR_W'(gi) >= ptr);
        end
    endgenerate

    // Prefer requests at or above ptr. If there are none, the search wraps,
    // and the lowest set bit of the full request vector wins.
    assign masked = req & mask;
    assign sel    = (|masked) ? masked : req;

    // Isolate the lowest set bit of the selected vector.
    assign gnt    = sel & (~sel + NUM_REQ'(1));
    assign valid  = |req;

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one status LED among NUM_REQ requesters. Each granted requester
// gets exactly N on/off blinks, then a dark gap, then a one-cycle ack.
module led_blink_scheduler
    import led_pkg::*;
#(
    parameter int CLK_IN      = 300,
    parameter int FREQ_OUT    = 5,
    parameter int NUM_REQ     = 4,
    parameter int CNT_W       = 4,
    parameter int GAP_PERIODS = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_en,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*CNT_W-1:0] i_count,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic                     o_busy,
    output logic                     o_led
);

    localparam int HALF    = led_half_period(CLK_IN, FREQ_OUT);
    localparam int GAP_LEN = GAP_PERIODS * 2 * HALF;
    // The timer must hold both reload values. The gap is normally the longer
    // one, but a zero-period gap would otherwise leave the timer with no bits.
    localparam int TMR_MAX = (GAP_LEN > HALF) ? GAP_LEN : HALF;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PTR_W   = $clog2(NUM_REQ);

    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(HALF - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = (GAP_LEN > 0) ? TMR_W'(GAP_LEN - 1) : '0;

    generate
        if (HALF < 1) begin : g_bad_half
            $error("led_blink_scheduler: CLK_IN/(2*FREQ_OUT) must be at least 1");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("led_blink_scheduler: NUM_REQ must be in 2..8");
        end
    endgenerate

    led_sched_state_t       state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       served_q, served_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   led_q, led_d;
    logic                   busy_q, busy_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic                   arb_valid;
    logic [PTR_W-1:0]       win_idx;
    logic [CNT_W-1:0]       win_cnt;
    logic [CNT_W-1:0]       count_arr [NUM_REQ];

    logic                   arb_fire;
    logic                   abort;
    logic                   tmr_zero;
    logic                   last_blink;
    logic                   seq_done;
    logic                   zero_done;

    // Split the packed count bus into one entry per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_count
            assign count_arr[gi] = i_count[gi*CNT_W +: CNT_W];
        end
    endgenerate

    led_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // Convert the one-hot arbiter grant to an index.
    always_comb begin
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                win_idx = PTR_W'(k);
            end
        end
    end

    assign win_cnt = count_arr[win_idx];

    // Returns the requester after idx, wrapping to 0 after the last one.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Arbitration is blocked while an ack is visible. A requester that drops
    // its request on the ack edge must not be served a second time.
    assign arb_fire   = (state_q == IDLE) && i_en && arb_valid && (ack_q == '0);
    assign abort      = (state_q != IDLE) && !i_en;
    assign tmr_zero   = (timer_q == '0);
    assign last_blink = (remaining_q <= CNT_W'(1));
    // A sequence normally ends when the gap expires. With a zero-length gap
    // it ends when the last dark phase expires.
    assign seq_done   = !abort && tmr_zero &&
                        ((state_q == GAP) ||
                         ((state_q == OFF) && last_blink && (GAP_LEN == 0)));
    assign zero_done  = arb_fire && (win_cnt == '0);

    // State register: the FSM, the counters and all registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            ptr_q       <= '0;
            served_q    <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            served_q    <= served_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: phase sequencing, timer reloads, blink countdown and
    // pointer advance. An abort takes priority over any phase end.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        served_d    = served_q;
        if (abort) begin
            // The pointer is left alone, so the aborted requester is served
            // first again.
            state_d     = IDLE;
            timer_d     = '0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_fire) begin
                        served_d    = win_idx;
                        remaining_d = win_cnt;
                        if (win_cnt != '0) begin
                            state_d = ON;
                            timer_d = HALF_LOAD;
                        end else begin
                            ptr_d = ptr_after(win_idx);
                        end
                    end
                end
                ON: begin
                    if (tmr_zero) begin
                        state_d = OFF;
                        timer_d = HALF_LOAD;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                OFF: begin
                    if (tmr_zero) begin
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - 1'b1;
                        end
                        if (!last_blink) begin
                            state_d = ON;
                            timer_d = HALF_LOAD;
                        end else if (GAP_LEN > 0) begin
                            state_d = GAP;
                            timer_d = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                            ptr_d   = ptr_after(served_q);
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        state_d = IDLE;
                        ptr_d   = ptr_after(served_q);
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output logic: the grant is held for the whole sequence and the ack is
    // a single-cycle pulse. The LED and busy outputs follow the next state,
    // so each output register matches the FSM state in the same cycle.
    always_comb begin
        grant_d = grant_q;
        ack_d   = '0;
        if (abort || seq_done) begin
            grant_d = '0;
        end else if (arb_fire && (win_cnt != '0)) begin
            grant_d = arb_gnt;
        end
        if (seq_done) begin
            ack_d = grant_q;
        end else if (zero_done) begin
            ack_d = arb_gnt;
        end
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    assign o_grant = grant_q;
    assign o_ack   = ack_q;
    assign o_busy  = busy_q;
    assign o_led   = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with the default parameters
// (HALF = 30 cycles, gap = 120 cycles, four requesters, 4-bit counts).
module tb_led_blink_scheduler;

    localparam int NREQ    = 4;
    localparam int CW      = 4;
    localparam int HALF    = 30;
    localparam int GAP_LEN = 120;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*CW-1:0] cnt = '0;
    logic [NREQ-1:0]   o_grant;
    logic [NREQ-1:0]   o_ack;
    logic              o_busy;
    logic              o_led;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_blink_scheduler #(
        .CLK_IN      (300),
        .FREQ_OUT    (5),
        .NUM_REQ     (NREQ),
        .CNT_W       (CW),
        .GAP_PERIODS (2)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_en      (en),
        .i_req     (req),
        .i_count   (cnt),
        .o_grant   (o_grant),
        .o_ack     (o_ack),
        .o_busy    (o_busy),
        .o_led     (o_led)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clock cycles and stop on the falling edge, where outputs are
    // sampled.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_count(input int id, input logic [CW-1:0] v);
        cnt[id*CW +: CW] = v;
    endtask

    // Called on the first falling edge after the grant (cycle 0). It walks the
    // whole sequence, checks the LED waveform, the held grant and the absence
    // of an ack, and then checks the ack cycle.
    task automatic play_seq(input int id, input int n, input bit drop);
        int total;
        int led_bad;
        int gnt_bad;
        int ack_bad;
        int busy_bad;
        logic [NREQ-1:0] oh;
        logic exp_led;
        total    = n * 2 * HALF + GAP_LEN;
        oh       = 4'b0001 << id;
        led_bad  = 0;
        gnt_bad  = 0;
        ack_bad  = 0;
        busy_bad = 0;
        for (int c = 0; c < total; c++) begin
            exp_led = (c < n * 2 * HALF) && ((c % (2 * HALF)) < HALF);
            if (o_led !== exp_led) led_bad++;
            if (o_grant !== oh) gnt_bad++;
            if (o_ack !== 4'b0000) ack_bad++;
            if (o_busy !== 1'b1) busy_bad++;
            step(1);
        end
        check_eq($sformatf("seq_r%0d_led_profile_errs", id), led_bad, 0);
        check_eq($sformatf("seq_r%0d_grant_hold_errs", id), gnt_bad, 0);
        check_eq($sformatf("seq_r%0d_early_ack_errs", id), ack_bad, 0);
        check_eq($sformatf("seq_r%0d_busy_errs", id), busy_bad, 0);
        check_eq($sformatf("seq_r%0d_ack", id), o_ack, oh);
        check_eq($sformatf("seq_r%0d_grant_clr", id), o_grant, 0);
        check_eq($sformatf("seq_r%0d_led_end", id), o_led, 0);
        check_eq($sformatf("seq_r%0d_busy_end", id), o_busy, 0);
        $display("served req%0d blinks=%0d grant_to_ack=%0d", id, n, total);
        if (drop) req[id] = 1'b0;
    endtask

    initial begin
        int ack_seen;

        // T1: reset state, then one 3-blink code for requester 0.
        en  = 1'b1;
        req = 4'b0001;
        set_count(0, 4'd3);
        step(2);
        check_eq("rst_led", o_led, 0);
        check_eq("rst_grant", o_grant, 0);
        check_eq("rst_ack", o_ack, 0);
        check_eq("rst_busy", o_busy, 0);
        rst_n = 1'b1;
        step(1);
        check_eq("t1_grant", o_grant, 4'b0001);
        check_eq("t1_led_first", o_led, 1);
        play_seq(0, 3, 1'b1);
        step(1);
        check_eq("t1_ack_single", o_ack, 0);
        check_eq("t1_no_reserve", o_grant, 0);
        step(1);
        check_eq("t1_idle_busy", o_busy, 0);

        // T2: requesters 0 and 2 held. After a reset (ptr = 0) the grants
        // alternate 0, 2, 0, 2.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        set_count(0, 4'd1);
        set_count(2, 4'd2);
        req = 4'b0101;
        step(1);
        check_eq("t2_grant_a0", o_grant, 4'b0001);
        play_seq(0, 1, 1'b0);
        step(1);
        check_eq("t2_blocked_a", o_grant, 0);
        step(1);
        check_eq("t2_grant_a2", o_grant, 4'b0100);
        play_seq(2, 2, 1'b0);
        step(1);
        check_eq("t2_blocked_b", o_grant, 0);
        step(1);
        check_eq("t2_grant_b0", o_grant, 4'b0001);
        play_seq(0, 1, 1'b1);
        step(1);
        check_eq("t2_blocked_c", o_grant, 0);
        step(1);
        check_eq("t2_grant_b2", o_grant, 4'b0100);
        play_seq(2, 2, 1'b1);
        step(2);

        // T3: zero-count request from requester 1, with ptr = 3.
        set_count(1, 4'd0);
        req[1] = 1'b1;
        step(1);
        check_eq("t3_zero_ack", o_ack, 4'b0010);
        check_eq("t3_zero_grant", o_grant, 0);
        check_eq("t3_zero_led", o_led, 0);
        check_eq("t3_zero_busy", o_busy, 0);
        req[1] = 1'b0;
        set_count(0, 4'd1);
        set_count(2, 4'd1);
        req[0] = 1'b1;
        req[2] = 1'b1;
        step(1);
        check_eq("t3_ack_gone", o_ack, 0);
        check_eq("t3_led_dark", o_led, 0);
        step(1);
        check_eq("t3_ptr_is_2", o_grant, 4'b0100);
        play_seq(2, 1, 1'b1);
        req[0] = 1'b0;
        step(2);

        // T4: abort during the second blink of requester 3 (ptr = 3).
        set_count(3, 4'd3);
        req[3] = 1'b1;
        step(1);
        check_eq("t4_grant", o_grant, 4'b1000);
        step(70);
        check_eq("t4_mid_on2", o_led, 1);
        en = 1'b0;
        set_count(0, 4'd1);
        req[0] = 1'b1;
        step(1);
        check_eq("t4_abort_led", o_led, 0);
        check_eq("t4_abort_grant", o_grant, 0);
        check_eq("t4_abort_busy", o_busy, 0);
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_ack !== 4'b0000) ack_seen++;
            step(1);
        end
        check_eq("t4_no_ack", ack_seen, 0);
        en = 1'b1;
        step(1);
        check_eq("t4_regrant3", o_grant, 4'b1000);
        play_seq(3, 3, 1'b1);
        req[0] = 1'b0;
        step(2);

        // T5: asynchronous reset during the gap. Afterwards ptr = 0, so
        // requester 1 wins over requester 2.
        set_count(2, 4'd1);
        req[2] = 1'b1;
        step(1);
        check_eq("t5_grant2", o_grant, 4'b0100);
        step(100);
        check_eq("t5_in_gap_busy", o_busy, 1);
        check_eq("t5_in_gap_led", o_led, 0);
        set_count(1, 4'd1);
        req[1] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_grant", o_grant, 0);
        check_eq("t5_async_busy", o_busy, 0);
        check_eq("t5_async_led", o_led, 0);
        check_eq("t5_async_ack", o_ack, 0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check_eq("t5_grant1_first", o_grant, 4'b0010);
        play_seq(1, 1, 1'b1);
        req[2] = 1'b0;
        step(2);

        // T6: the count changes from 2 to 5 after the grant; only 2 blinks play.
        set_count(2, 4'd2);
        req[2] = 1'b1;
        step(1);
        check_eq("t6_grant", o_grant, 4'b0100);
        set_count(2, 4'd5);
        play_seq(2, 2, 1'b1);
        step(2);
        check_eq("t6_idle", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
